program_readback_tx: RTL

- Reads back the CPU instruction memory over its read port and streams each 16-bit instruction out of a UART TX line, high byte first, in 8N1 format.
- It is the reader counterpart to the program-download write path: the write path fills instruction slots, and this block dumps them for host-side verification.
- It sits in the Arty top level, runs on the same clock as the CPU, and is triggered by a button pulse.

---
 rtl/arty_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 69 ++++++
 rtl/program_readback_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/arty_pkg.sv
// Shared constants and types for the Arty debug blocks (UART framing, instruction
// words and the program readback state machine).
package arty_pkg;

  localparam int UART_CLKS_PER_BIT_115200 = 868;
  localparam int UART_FRAME_BITS          = 10;

  typedef logic [15:0] instr_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND_HI,
    SEND_LO,
    NEXT
  } readback_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter. A load is accepted when idle or in the final cycle of a
// stop bit, so consecutive bytes go out back-to-back with no idle gap.
module uart_tx_byte
  import arty_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [BAUD_W-1:0] r_baudCnt;
  logic [3:0]        r_bitCnt;
  logic [7:0]        r_data;
  logic              r_tx;
  logic              r_active;
  logic              w_bitEnd;
  logic              w_frameEnd;
  logic              w_accept;
  logic              w_nextBit;

  assign w_bitEnd   = (r_baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_frameEnd = r_active && w_bitEnd && (r_bitCnt == 4'(UART_FRAME_BITS - 1));
  assign w_accept   = load && (!r_active || w_frameEnd);
  // r_bitCnt is the bit now on the line; bits 1..8 carry data LSB first, bit 9 is stop.
  assign w_nextBit  = (r_bitCnt == 4'd8) ? 1'b1 : r_data[r_bitCnt[2:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_data    <= '0;
    end else if (w_accept) begin
      r_data    <= data;
      r_active  <= 1'b1;
      r_tx      <= 1'b0;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_baudCnt <= '0;
        if (r_bitCnt == 4'(UART_FRAME_BITS - 1)) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
          r_bitCnt <= '0;
        end else begin
          r_bitCnt <= r_bitCnt + 4'd1;
          r_tx     <= w_nextBit;
        end
      end else begin
        r_baudCnt <= r_baudCnt + BAUD_W'(1);
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_active;
  assign tx_done = w_frameEnd;

endmodule

// File: rtl/program_readback_tx.sv
// Program readback: walks instruction slots FIRST_INDEX..LAST_INDEX, reading each
// word from the instruction memory and sending it over UART high byte first.
module program_readback_tx
  import arty_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int FIRST_INDEX  = 10,
  parameter int LAST_INDEX   = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] read_index,
  input  logic [DATA_W-1:0] read_instruction,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  readback_state_t   r_state;
  readback_state_t   w_nextState;
  logic [ADDR_W-1:0] r_readIndex;
  instr_t            r_hold;
  instr_t            w_instr;
  logic              w_atLast;
  logic              w_load;
  logic [7:0]        w_txData;
  logic              w_txBusy;
  logic              w_txDone;

  // Instructions are 16 bits wide; any other DATA_W shows up here as a width mismatch.
  assign w_instr  = read_instruction;
  assign w_atLast = (r_readIndex == ADDR_W'(LAST_INDEX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_readIndex <= ADDR_W'(FIRST_INDEX);
      r_hold      <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && start) begin
        r_readIndex <= ADDR_W'(FIRST_INDEX);
      end else if (r_state == NEXT && !w_atLast) begin
        r_readIndex <= r_readIndex + ADDR_W'(1);
      end
      if (r_state == CAPTURE) begin
        r_hold <= w_instr;
      end
    end
  end

  // Loads are issued on the transition into a send state, so the start bit of the
  // high byte occupies the first SEND_HI cycle and the low byte follows its stop bit.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_txData    = r_hold[15:8];
    case (r_state)
      IDLE:    if (start) w_nextState = FETCH;
      FETCH:   w_nextState = CAPTURE;
      CAPTURE: begin
        w_load      = 1'b1;
        w_txData    = w_instr[15:8];
        w_nextState = SEND_HI;
      end
      SEND_HI: begin
        if (w_txDone) begin
          w_load      = 1'b1;
          w_txData    = r_hold[7:0];
          w_nextState = SEND_LO;
        end
      end
      SEND_LO: if (w_txDone) w_nextState = NEXT;
      NEXT:    w_nextState = w_atLast ? IDLE : FETCH;
      default: w_nextState = IDLE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uartTx (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .data    (w_txData),
    .tx      (tx),
    .tx_busy (w_txBusy),
    .tx_done (w_txDone)
  );

  assign read_index = r_readIndex;
  assign busy       = (r_state != IDLE) || w_txBusy;
  assign done       = (r_state == NEXT) && w_atLast;

endmodule
